// File: rtl/seven_seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver for active-low Basys3 pins.
// The display value is latched once per frame so digits never tear; leading zeros can be blanked.
module seven_seg_scan_driver #(
    parameter int unsigned REFRESH_DIV  = 100_000,
    parameter int unsigned BLANK_CYCLES = 1_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_sel,
    input  logic        blank_lz,
    input  logic        display_en,
    output logic        CA,
    output logic        CB,
    output logic        CC,
    output logic        CD,
    output logic        CE,
    output logic        CF,
    output logic        CG,
    output logic        DP,
    output logic        AN1,
    output logic        AN2,
    output logic        AN3,
    output logic        AN4,
    output logic        frame_start
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       digit_q, digit_d;
    logic [15:0]      shadow_val_q, shadow_val_d;
    logic [3:0]       shadow_dp_q, shadow_dp_d;
    logic             shadow_lz_q, shadow_lz_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             frame_start_q, frame_start_d;

    logic             slot_end;
    logic             frame_end;
    logic [3:0]       blank;
    logic [3:0]       nib;
    logic             digit_on;

    // Active-low {CA..CG} pattern for one hex digit
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    always_comb begin
        slot_end      = (cnt_q == CNT_MAX);
        frame_end     = slot_end && (digit_q == 2'd3);
        cnt_d         = slot_end ? '0 : cnt_q + CNT_W'(1);
        digit_d       = slot_end ? digit_q + 2'd1 : digit_q;
        shadow_val_d  = shadow_val_q;
        shadow_dp_d   = shadow_dp_q;
        shadow_lz_d   = shadow_lz_q;
        frame_start_d = frame_end;

        if (frame_end) begin
            shadow_val_d = value_in;
            shadow_dp_d  = dp_sel;
            shadow_lz_d  = blank_lz;
        end

        // A digit is a leading zero when it and every digit left of it are zero
        blank[0] = 1'b0;
        blank[1] = shadow_lz_q && (shadow_val_q[15:4]  == 12'h000);
        blank[2] = shadow_lz_q && (shadow_val_q[15:8]  == 8'h00);
        blank[3] = shadow_lz_q && (shadow_val_q[15:12] == 4'h0);

        nib      = shadow_val_q[{digit_q, 2'b00} +: 4];
        digit_on = display_en && (cnt_q >= CNT_BLANK) && !blank[digit_q];

        an_d  = 4'hF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (digit_on) begin
            an_d[digit_q] = 1'b0;
            seg_d         = hex_to_seg(nib);
            dp_d          = ~shadow_dp_q[digit_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= '0;
            digit_q       <= 2'd0;
            shadow_val_q  <= 16'h0000;
            shadow_dp_q   <= 4'h0;
            shadow_lz_q   <= 1'b0;
            an_q          <= 4'hF;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            digit_q       <= digit_d;
            shadow_val_q  <= shadow_val_d;
            shadow_dp_q   <= shadow_dp_d;
            shadow_lz_q   <= shadow_lz_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign {CA, CB, CC, CD, CE, CF, CG} = seg_q;
    assign {AN4, AN3, AN2, AN1}         = an_q;
    assign DP                           = dp_q;
    assign frame_start                  = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with a per-cycle scoreboard of expected pin states.
module tb_seven_seg_scan_driver;

    localparam int unsigned RDIV = 8;
    localparam int unsigned BLNK = 2;

    localparam logic [6:0] SEG_TBL [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value_in;
    logic [3:0]  dp_sel;
    logic        blank_lz;
    logic        display_en;
    logic        CA, CB, CC, CD, CE, CF, CG, DP;
    logic        AN1, AN2, AN3, AN4;
    logic        frame_start;

    seven_seg_scan_driver #(.REFRESH_DIV(RDIV), .BLANK_CYCLES(BLNK)) dut (
        .clk(clk), .reset(reset), .value_in(value_in), .dp_sel(dp_sel),
        .blank_lz(blank_lz), .display_en(display_en),
        .CA(CA), .CB(CB), .CC(CC), .CD(CD), .CE(CE), .CF(CF), .CG(CG), .DP(DP),
        .AN1(AN1), .AN2(AN2), .AN3(AN3), .AN4(AN4), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    int          m_cnt, m_dig;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic        m_lz;
    logic [3:0]  o_an;
    logic [6:0]  o_seg;
    logic        o_dp, o_fs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp_v, cyc);
        end
    endtask

    // Push the expected pin state for the coming edge, clock once, then compare
    task automatic step();
        exp_t e, got;
        logic on, blk;
        e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.fs = 1'b0;
        if (reset) begin
            m_cnt = 0; m_dig = 0; m_val = '0; m_dp = '0; m_lz = 1'b0;
        end else begin
            blk = m_lz && (m_dig != 0) && ((m_val >> (4 * m_dig)) == 16'h0);
            on  = display_en && (m_cnt >= BLNK) && !blk;
            if (on) begin
                e.an  = ~(4'b0001 << m_dig);
                e.seg = SEG_TBL[(m_val >> (4 * m_dig)) & 16'hF];
                e.dp  = ~m_dp[m_dig];
            end
            e.fs = (m_cnt == RDIV - 1) && (m_dig == 3);
            if (e.fs) begin
                m_val = value_in; m_dp = dp_sel; m_lz = blank_lz;
            end
            if (m_cnt == RDIV - 1) begin
                m_cnt = 0; m_dig = (m_dig + 1) % 4;
            end else begin
                m_cnt++;
            end
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        o_an  = {AN4, AN3, AN2, AN1};
        o_seg = {CA, CB, CC, CD, CE, CF, CG};
        o_dp  = DP;
        o_fs  = frame_start;
        got   = sb_q.pop_front();
        chk("an",  o_an,  got.an);
        chk("seg", o_seg, got.seg);
        chk("dp",  o_dp,  got.dp);
        chk("frame_start", o_fs, got.fs);
        chk("an_onehot", ($countones(~o_an) <= 1) ? 1 : 0, 1);
    endtask

    // Step until frame_start is seen; n returns the number of steps taken
    task automatic wait_fs(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!o_fs && n < 40);
        if (!o_fs) chk("fs_timeout", o_fs, 1);
    endtask

    initial begin
        int n, m, lit1, lit2;
        reset = 1'b1; display_en = 1'b1; blank_lz = 1'b0; dp_sel = 4'h0; value_in = 16'h0;
        for (int i = 0; i < 3; i++) begin
            value_in = 16'($urandom); dp_sel = 4'($urandom); blank_lz = 1'($urandom);
            step();
        end
        chk("rst_an", o_an, 4'hF);
        chk("rst_seg", o_seg, 7'h7F);
        chk("rst_fs", o_fs, 0);

        // First frame after reset release
        reset = 1'b0; value_in = 16'h12AF; dp_sel = 4'h0; blank_lz = 1'b0; display_en = 1'b1;
        wait_fs(n);
        chk("fs_first", n, 32);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("s2_an1", o_an[0], (k >= 3) ? 0 : 1);
            if (k >= 3) chk("s2_seg_F", o_seg, 7'b0111000);
        end
        for (int k = 0; k < 16; k++) step();
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k >= 3) begin
                chk("s2_an4", o_an, 4'b0111);
                chk("s2_seg_1", o_seg, 7'b1001111);
            end
        end

        // Leading-zero blanking
        value_in = 16'h0050; blank_lz = 1'b1;
        wait_fs(n);
        lit1 = 0; lit2 = 0;
        for (int k = 0; k < 32; k++) begin
            step();
            chk("s3_an43_dark", o_an[3:2], 2'b11);
            if (!o_an[1]) begin lit2++; chk("s3_seg_5", o_seg, 7'b0100100); end
            if (!o_an[0]) begin lit1++; chk("s3_seg_0", o_seg, 7'b0000001); end
        end
        chk("s3_an2_lit", lit2, 6);
        chk("s3_an1_lit", lit1, 6);
        value_in = 16'h0000;
        wait_fs(n);
        lit1 = 0;
        for (int k = 0; k < 32; k++) begin
            step();
            chk("s3z_an_dark", o_an[3:1], 3'b111);
            if (!o_an[0]) begin lit1++; chk("s3z_seg_0", o_seg, 7'b0000001); end
        end
        chk("s3z_an1_lit", lit1, 6);

        // Mid-frame input change must not tear the frame
        value_in = 16'h1111; blank_lz = 1'b0;
        wait_fs(n);
        for (int k = 0; k < 32; k++) begin
            if (k == 11) value_in = 16'h2222;
            step();
            if (o_an != 4'hF) chk("s4_seg_1", o_seg, 7'b1001111);
        end
        chk("s4_fs", o_fs, 1);
        for (int k = 0; k < 32; k++) begin
            step();
            if (o_an != 4'hF) chk("s4_seg_2", o_seg, 7'b0010010);
        end

        // Display disable mid-slot keeps timing running
        for (int k = 0; k < 4; k++) step();
        display_en = 1'b0;
        step();
        chk("s5_an_off", o_an, 4'hF);
        chk("s5_seg_off", o_seg, 7'h7F);
        for (int k = 0; k < 6; k++) step();
        display_en = 1'b1;
        wait_fs(m);
        chk("s5_period", 11 + m, 32);

        // Decimal point on digit 3
        dp_sel = 4'b0100;
        wait_fs(n);
        lit1 = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            chk("s6_dp_an3", o_dp, o_an[2]);
            if (!o_dp) lit1++;
        end
        chk("s6_dp_count", lit1, 6);

        // Reset mid-frame returns to the reset state and shows "0000"
        for (int k = 0; k < 5; k++) step();
        reset = 1'b1;
        step();
        chk("s7_rst_an", o_an, 4'hF);
        chk("s7_rst_dp", o_dp, 1);
        reset = 1'b0; value_in = 16'hBEEF;
        for (int k = 0; k < 32; k++) begin
            step();
            if (o_an != 4'hF) chk("s7_seg_0", o_seg, 7'b0000001);
        end

        chk("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
